// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32 integer-pipeline types and constants. Holds the
//               XLEN and register-index widths, the register and XLEN types,
//               and the writeback-source select encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int REG_INDEX = 5;
    localparam int NUM_REGS  = 32;

    typedef logic [REG_INDEX-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xlen_t;

    localparam reg_idx_t REG_ZERO = '0;

    // Encoding matches the raw mem_to_reg control bit from MEM/WB.
    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_sel_e;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/wb_mux.sv
`default_nettype none
// ============================================================================
// Module      : wb_mux
// Description : Writeback source select and effective write-enable.
//               Chooses load data or the ALU result, and qualifies the
//               register write so that writes to x0 never take effect.
// Ports       : mem_to_reg_in  - 1 selects data_mem_in, 0 selects alu_res_in
//               reg_write_in   - writeback enable from MEM/WB
//               rd_in          - destination register index
//               data_mem_in    - load data
//               alu_res_in     - ALU result
//               wb_data_out    - selected writeback value (combinational)
//               wb_en_out      - reg_write_in && rd_in != x0
// Revision    : 1.0 - initial release
// ============================================================================
module wb_mux
    import riscv_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int INDEX = REG_INDEX
) (
    input  logic             mem_to_reg_in,
    input  logic             reg_write_in,
    input  logic [INDEX-1:0] rd_in,
    input  logic [WIDTH-1:0] data_mem_in,
    input  logic [WIDTH-1:0] alu_res_in,
    output logic [WIDTH-1:0] wb_data_out,
    output logic             wb_en_out
);

    wb_sel_e wb_sel;

    assign wb_sel = wb_sel_e'(mem_to_reg_in);

    always_comb begin
        wb_data_out = alu_res_in;
        if (wb_sel == WB_MEM) begin
            wb_data_out = data_mem_in;
        end
        // x0 is hardwired to zero, so a write aimed at it is dropped here and
        // never reaches the array or the forwarding unit.
        wb_en_out = reg_write_in && (rd_in != '0);
    end

endmodule : wb_mux
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : Writeback stage plus 32-entry integer register file.
//               Commits the selected writeback value one clock after it is
//               presented, offers two combinational read ports with
//               same-cycle write-through bypass, and exports the resolved
//               writeback value/enable for forwarding.
// Ports       : clk_in         - clock, rising edge
//               rst_in         - asynchronous active-low reset (clears array)
//               mem_to_reg_in  - writeback source select
//               reg_write_in   - writeback enable
//               rd_in          - destination index
//               data_mem_in    - load data
//               alu_res_in     - ALU result
//               rs1_addr_in    - read port 1 address
//               rs2_addr_in    - read port 2 address
//               rs1_data_out   - read port 1 data
//               rs2_data_out   - read port 2 data
//               wb_data_out    - resolved writeback value
//               wb_en_out      - effective write enable
//               retire_in      - (WB_RETIRE_CNT_EN) valid instruction in WB
//               instret_out    - (WB_RETIRE_CNT_EN) 64-bit retire count
// Options     : define WB_RETIRE_CNT_EN to add the instret counter.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile
    import riscv_pkg::*;
#(
    parameter int WIDTH    = XLEN,
    parameter int INDEX    = REG_INDEX,
    parameter int NUM_REGS = riscv_pkg::NUM_REGS
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             mem_to_reg_in,
    input  logic             reg_write_in,
    input  logic [INDEX-1:0] rd_in,
    input  logic [WIDTH-1:0] data_mem_in,
    input  logic [WIDTH-1:0] alu_res_in,
    input  logic [INDEX-1:0] rs1_addr_in,
    input  logic [INDEX-1:0] rs2_addr_in,
    output logic [WIDTH-1:0] rs1_data_out,
    output logic [WIDTH-1:0] rs2_data_out,
    output logic [WIDTH-1:0] wb_data_out,
    output logic             wb_en_out
`ifdef WB_RETIRE_CNT_EN
    ,
    input  logic             retire_in,
    output logic [63:0]      instret_out
`endif
);

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];

    wb_mux #(
        .WIDTH (WIDTH),
        .INDEX (INDEX)
    ) u_wb_mux (
        .mem_to_reg_in (mem_to_reg_in),
        .reg_write_in  (reg_write_in),
        .rd_in         (rd_in),
        .data_mem_in   (data_mem_in),
        .alu_res_in    (alu_res_in),
        .wb_data_out   (wb_data_out),
        .wb_en_out     (wb_en_out)
    );

    always_comb begin
        regs_d = regs_q;
        if (wb_en_out) begin
            regs_d[rd_in] = wb_data_out;
        end
        // Entry 0 is held at zero so the x0 flop is constant.
        regs_d[0] = '0;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: x0 forced to zero, then bypass the in-flight writeback so an
    // ID read in the same cycle as WB sees the new value, else the array.
    always_comb begin
        rs1_data_out = regs_q[rs1_addr_in];
        if (rs1_addr_in == '0) begin
            rs1_data_out = '0;
        end else if (wb_en_out && (rs1_addr_in == rd_in)) begin
            rs1_data_out = wb_data_out;
        end

        rs2_data_out = regs_q[rs2_addr_in];
        if (rs2_addr_in == '0) begin
            rs2_data_out = '0;
        end else if (wb_en_out && (rs2_addr_in == rd_in)) begin
            rs2_data_out = wb_data_out;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] instret_q;
    logic [63:0] instret_d;

    // Counts every retiring instruction, independent of register writes;
    // wraps naturally at 2^64.
    always_comb begin
        instret_d = instret_q;
        if (retire_in) begin
            instret_d = instret_q + 64'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret_out = instret_q;
`endif

endmodule : wb_regfile
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile
// Description : Self-checking testbench for wb_regfile. Expected values are
//               pushed to a scoreboard queue when stimulus is applied and
//               popped/compared once the DUT outputs are sampled.
// Options     : define WB_RETIRE_CNT_EN to also exercise the instret counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        mem_to_reg_in;
    logic        reg_write_in;
    logic [4:0]  rd_in;
    logic [31:0] data_mem_in;
    logic [31:0] alu_res_in;
    logic [4:0]  rs1_addr_in;
    logic [4:0]  rs2_addr_in;
    logic [31:0] rs1_data_out;
    logic [31:0] rs2_data_out;
    logic [31:0] wb_data_out;
    logic        wb_en_out;
`ifdef WB_RETIRE_CNT_EN
    logic        retire_in;
    logic [63:0] instret_out;
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q [$];
    logic [63:0] exp_v;
    logic [31:0] model [32];

    always #5 clk_in = ~clk_in;

    wb_regfile dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .mem_to_reg_in (mem_to_reg_in),
        .reg_write_in  (reg_write_in),
        .rd_in         (rd_in),
        .data_mem_in   (data_mem_in),
        .alu_res_in    (alu_res_in),
        .rs1_addr_in   (rs1_addr_in),
        .rs2_addr_in   (rs2_addr_in),
        .rs1_data_out  (rs1_data_out),
        .rs2_data_out  (rs2_data_out),
        .wb_data_out   (wb_data_out),
        .wb_en_out     (wb_en_out)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_in     (retire_in),
        .instret_out   (instret_out)
`endif
    );

    // Apply writeback inputs (blocking, from the calling initial block).
    task automatic drive_wb(input logic we, input logic m2r, input logic [4:0] rd,
                            input logic [31:0] mem, input logic [31:0] alu);
        reg_write_in  = we;
        mem_to_reg_in = m2r;
        rd_in         = rd;
        data_mem_in   = mem;
        alu_res_in    = alu;
    endtask

    // Advance through one rising edge, keeping the reference array in step.
    task automatic step();
        @(posedge clk_in);
        if (rst_in && reg_write_in && rd_in != 5'd0)
            model[rd_in] = mem_to_reg_in ? data_mem_in : alu_res_in;
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        model_clear();
        drive_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        rs1_addr_in = 5'd5;
        rs2_addr_in = 5'd31;
        @(negedge clk_in); #1;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        exp_v = exp_q.pop_front(); checks++;
        if (rs1_data_out !== exp_v[31:0]) begin errors++; $display("FAIL reset_rs1 got %h expected %h", rs1_data_out, exp_v[31:0]); end
        exp_v = exp_q.pop_front(); checks++;
        if (rs2_data_out !== exp_v[31:0]) begin errors++; $display("FAIL reset_rs2 got %h expected %h", rs2_data_out, exp_v[31:0]); end
        exp_v = exp_q.pop_front(); checks++;
        if (wb_en_out !== exp_v[0]) begin errors++; $display("FAIL reset_wb_en got %b expected %b", wb_en_out, exp_v[0]); end

        @(negedge clk_in);
        rst_in = 1'b1;
        drive_wb(1'b1, 1'b0, 5'd5, 32'h0, 32'hDEADBEEF);
        step();
        @(negedge clk_in);
        drive_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        exp_q.push_back({32'h0, model[5]});
        exp_v = exp_q.pop_front(); checks++;
        if (rs1_data_out !== exp_v[31:0]) begin errors++; $display("FAIL reset_pre_x5 got %h expected %h", rs1_data_out, exp_v[31:0]); end

        // Mid-cycle asynchronous reset, no clock edge in between.
        #1;
        rst_in = 1'b0;
        model_clear();
        #1;
        exp_q.push_back(64'h0);
        exp_v = exp_q.pop_front(); checks++;
        if (rs1_data_out !== exp_v[31:0]) begin errors++; $display("FAIL reset_async_x5 got %h expected %h", rs1_data_out, exp_v[31:0]); end

        // Write presented while in reset: bypass and enable still follow inputs.
        drive_wb(1'b1, 1'b0, 5'd6, 32'h0, 32'h00000055);
        rs1_addr_in = 5'd6;
        #1;
        exp_q.push_back(64'h1);
        exp_q.push_back(64'h55);
        exp_v = exp_q.pop_front(); checks++;
        if (wb_en_out !== exp_v[0]) begin errors++; $display("FAIL reset_wb_en_follow got %b expected %b", wb_en_out, exp_v[0]); end
        exp_v = exp_q.pop_front(); checks++;
        if (rs1_data_out !== exp_v[31:0]) begin errors++; $display("FAIL reset_bypass got %h expected %h", rs1_data_out, exp_v[31:0]); end
        step();
        @(negedge clk_in);
        rst_in = 1'b1;
        drive_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        exp_q.push_back(64'h0);
        exp_v = exp_q.pop_front(); checks++;
        if (rs1_data_out !== exp_v[31:0]) begin errors++; $display("FAIL reset_lost_write got %h expected %h", rs1_data_out, exp_v[31:0]); end
    endtask

    task automatic test_write_read();
        @(negedge clk_in);
        drive_wb(1'b1, 1'b0, 5'd7, 32'h0, 32'h00001234);
        step();
        @(negedge clk_in);
        drive_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        rs1_addr_in = 5'd7;
        #1;
        exp_q.push_back(64'h00001234);
        exp_v = exp_q.pop_front(); checks++;
        if (rs1_data_out !== exp_v[31:0]) begin errors++; $display("FAIL wr_x7 got %h expected %h", rs1_data_out, exp_v[31:0]); end
        step();
        step();
        exp_q.push_back(64'h00001234);
        exp_v = exp_q.pop_front(); checks++;
        if (rs1_data_out !== exp_v[31:0]) begin errors++; $display("FAIL wr_x7_hold got %h expected %h", rs1_data_out, exp_v[31:0]); end
    endtask

    task automatic test_mux_bypass();
        @(negedge clk_in);
        drive_wb(1'b1, 1'b1, 5'd3, 32'hCAFEF00D, 32'h11111111);
        rs1_addr_in = 5'd3;
        rs2_addr_in = 5'd3;
        #1;
        exp_q.push_back(64'hCAFEF00D);
        exp_q.push_back(64'hCAFEF00D);
        exp_q.push_back(64'hCAFEF00D);
        exp_v = exp_q.pop_front(); checks++;
        if (wb_data_out !== exp_v[31:0]) begin errors++; $display("FAIL mux_mem got %h expected %h", wb_data_out, exp_v[31:0]); end
        exp_v = exp_q.pop_front(); checks++;
        if (rs1_data_out !== exp_v[31:0]) begin errors++; $display("FAIL bypass_rs1 got %h expected %h", rs1_data_out, exp_v[31:0]); end
        exp_v = exp_q.pop_front(); checks++;
        if (rs2_data_out !== exp_v[31:0]) begin errors++; $display("FAIL bypass_rs2 got %h expected %h", rs2_data_out, exp_v[31:0]); end
        step();
        @(negedge clk_in);
        drive_wb(1'b0, 1'b0, 5'd3, 32'hCAFEF00D, 32'h11111111);
        #1;
        exp_q.push_back(64'hCAFEF00D);
        exp_q.push_back(64'h11111111);
        exp_v = exp_q.pop_front(); checks++;
        if (rs1_data_out !== exp_v[31:0]) begin errors++; $display("FAIL array_x3 got %h expected %h", rs1_data_out, exp_v[31:0]); end
        exp_v = exp_q.pop_front(); checks++;
        if (wb_data_out !== exp_v[31:0]) begin errors++; $display("FAIL mux_alu got %h expected %h", wb_data_out, exp_v[31:0]); end
    endtask

    task automatic test_x0();
        @(negedge clk_in);
        drive_wb(1'b1, 1'b0, 5'd0, 32'h0, 32'hFFFFFFFF);
        rs1_addr_in = 5'd0;
        rs2_addr_in = 5'd0;
        #1;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        exp_v = exp_q.pop_front(); checks++;
        if (wb_en_out !== exp_v[0]) begin errors++; $display("FAIL x0_wb_en got %b expected %b", wb_en_out, exp_v[0]); end
        exp_v = exp_q.pop_front(); checks++;
        if (rs1_data_out !== exp_v[31:0]) begin errors++; $display("FAIL x0_pre got %h expected %h", rs1_data_out, exp_v[31:0]); end
        step();
        exp_q.push_back(64'h0);
        exp_v = exp_q.pop_front(); checks++;
        if (rs1_data_out !== exp_v[31:0]) begin errors++; $display("FAIL x0_post got %h expected %h", rs1_data_out, exp_v[31:0]); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk_in);
        drive_wb(1'b1, 1'b0, 5'd9, 32'h0, 32'h0000000A);
        rs2_addr_in = 5'd9;
        step();
        exp_q.push_back(64'hA);
        exp_v = exp_q.pop_front(); checks++;
        if (rs2_data_out !== exp_v[31:0]) begin errors++; $display("FAIL b2b_after1 got %h expected %h", rs2_data_out, exp_v[31:0]); end
        @(negedge clk_in);
        drive_wb(1'b1, 1'b0, 5'd9, 32'h0, 32'h0000000B);
        #1;
        exp_q.push_back(64'hB);
        exp_v = exp_q.pop_front(); checks++;
        if (rs2_data_out !== exp_v[31:0]) begin errors++; $display("FAIL b2b_bypass got %h expected %h", rs2_data_out, exp_v[31:0]); end
        step();
        @(negedge clk_in);
        drive_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        exp_q.push_back(64'hB);
        exp_v = exp_q.pop_front(); checks++;
        if (rs2_data_out !== exp_v[31:0]) begin errors++; $display("FAIL b2b_array got %h expected %h", rs2_data_out, exp_v[31:0]); end
    endtask

    task automatic test_random();
        logic        we, m2r, en;
        logic [4:0]  rd;
        logic [31:0] wb;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_in);
            if ($urandom_range(0, 4) == 0) begin
                we = 1'b0; rd = 5'd0;   // flushed bubble
            end else begin
                we = 1'($urandom_range(0, 1));
                rd = 5'($urandom_range(0, 31));
            end
            m2r = 1'($urandom_range(0, 1));
            drive_wb(we, m2r, rd, $urandom, $urandom);
            rs1_addr_in = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2_addr_in = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            wb = m2r ? data_mem_in : alu_res_in;
            en = we && (rd != 5'd0);
            exp_q.push_back({63'h0, en});
            exp_q.push_back({32'h0, wb});
            exp_q.push_back({32'h0, (rs1_addr_in == 5'd0) ? 32'h0 :
                             (en && rs1_addr_in == rd) ? wb : model[rs1_addr_in]});
            exp_q.push_back({32'h0, (rs2_addr_in == 5'd0) ? 32'h0 :
                             (en && rs2_addr_in == rd) ? wb : model[rs2_addr_in]});
            #1;
            exp_v = exp_q.pop_front(); checks++;
            if (wb_en_out !== exp_v[0]) begin errors++; $display("FAIL rand_wb_en cyc %0d got %b expected %b", n, wb_en_out, exp_v[0]); end
            exp_v = exp_q.pop_front(); checks++;
            if (wb_data_out !== exp_v[31:0]) begin errors++; $display("FAIL rand_wb_data cyc %0d got %h expected %h", n, wb_data_out, exp_v[31:0]); end
            exp_v = exp_q.pop_front(); checks++;
            if (rs1_data_out !== exp_v[31:0]) begin errors++; $display("FAIL rand_rs1 cyc %0d got %h expected %h", n, rs1_data_out, exp_v[31:0]); end
            exp_v = exp_q.pop_front(); checks++;
            if (rs2_data_out !== exp_v[31:0]) begin errors++; $display("FAIL rand_rs2 cyc %0d got %h expected %h", n, rs2_data_out, exp_v[31:0]); end
            step();
        end
        @(negedge clk_in);
        drive_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

`ifdef WB_RETIRE_CNT_EN
    task automatic test_retire();
        @(negedge clk_in);
        rst_in = 1'b0;
        model_clear();
        retire_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        retire_in = 1'b1;
        repeat (5) step();
        @(negedge clk_in);
        retire_in = 1'b0;
        repeat (2) step();
        @(negedge clk_in);
        retire_in = 1'b1;
        step();
        @(negedge clk_in);
        retire_in = 1'b0;
        #1;
        exp_q.push_back(64'd6);
        exp_v = exp_q.pop_front(); checks++;
        if (instret_out !== exp_v) begin errors++; $display("FAIL instret_count got %0d expected %0d", instret_out, exp_v); end

        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        @(negedge clk_in);
        retire_in = 1'b1;
        step();
        @(negedge clk_in);
        retire_in = 1'b0;
        #1;
        exp_q.push_back(64'd0);
        exp_v = exp_q.pop_front(); checks++;
        if (instret_out !== exp_v) begin errors++; $display("FAIL instret_wrap got %0d expected %0d", instret_out, exp_v); end
    endtask
`endif

    initial begin
`ifdef WB_RETIRE_CNT_EN
        retire_in = 1'b0;
`endif
        test_reset();
        test_write_read();
        test_mux_bypass();
        test_x0();
        test_back_to_back();
        test_random();
`ifdef WB_RETIRE_CNT_EN
        test_retire();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_wb_regfile
`default_nettype wire
